// File: rtl/mrd_sink_pack_p4_if.sv
// Serial-sample side and 4-lane beat side of the mixed-radix DFT input packer.
// The producer/consumer of the serial stream uses master; the packer uses slave.
interface mrd_sink_pack_p4_if #(
    parameter int DW    = 18,
    parameter int wPTS  = 12,
    parameter int wDROP = 16
);
    logic                in_valid;
    logic                in_sop;
    logic                in_eop;
    logic [DW-1:0]       in_real;
    logic [DW-1:0]       in_imag;
    logic [wPTS-1:0]     in_dftpts;
    logic [5:0]          in_size;
    logic                sink_ready;
    logic                out_valid;
    logic                out_sop;
    logic                out_eop;
    logic [4*DW-1:0]     out_real;
    logic [4*DW-1:0]     out_imag;
    logic [wPTS-1:0]     out_dftpts;
    logic [5:0]          out_size;
    logic                err_len;
    logic [wDROP-1:0]    drop_cnt;

    modport master (
        output in_valid, in_sop, in_eop, in_real, in_imag,
        output in_dftpts, in_size, sink_ready,
        input  out_valid, out_sop, out_eop, out_real, out_imag,
        input  out_dftpts, out_size, err_len, drop_cnt
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_real, in_imag,
        input  in_dftpts, in_size, sink_ready,
        output out_valid, out_sop, out_eop, out_real, out_imag,
        output out_dftpts, out_size, err_len, drop_cnt
    );
endinterface

// File: rtl/mrd_sink_pack_p4.sv
// Packs serial complex samples into 4-lane beats with sop/eop framing,
// length checking and a saturating count of packets the memory top refused.
module mrd_sink_pack_p4 #(
    parameter int DW    = 18,
    parameter int wPTS  = 12,
    parameter int wDROP = 16
) (
    input  logic clk,
    input  logic rst,
    mrd_sink_pack_p4_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PACK, DROP} state_t;

    state_t                 state_q, state_d;
    logic [wPTS-1:0]        cnt_q, cnt_d, pts_q, pts_d;
    logic [wPTS-1:0]        cur_cnt, cnt_inc;
    logic [5:0]             size_q, size_d;
    logic [3:0][DW-1:0]     re_q, re_d, im_q, im_d;
    logic [3:0][DW-1:0]     cur_re, cur_im;
    logic                   first_q, first_d;
    logic                   sop, ok, take, fin, emit;
    logic [1:0]             lane;

    logic                   ov_q, ov_d, osop_q, osop_d, oeop_q, oeop_d;
    logic                   err_q, err_d;
    logic [3:0][DW-1:0]     ore_q, ore_d, oim_q, oim_d;
    logic [wPTS-1:0]        opts_q, opts_d;
    logic [5:0]             osz_q, osz_d;
    logic [wDROP-1:0]       drop_q, drop_d;

    assign sop = bus.in_valid & bus.in_sop;
    assign ok  = bus.sink_ready && (bus.in_dftpts != '0) &&
                 (bus.in_dftpts[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pts_d   = pts_q;
        size_d  = size_q;
        re_d    = re_q;
        im_d    = im_q;
        first_d = first_q;
        ov_d    = 1'b0;
        osop_d  = 1'b0;
        oeop_d  = 1'b0;
        ore_d   = '0;
        oim_d   = '0;
        opts_d  = '0;
        osz_d   = '0;
        err_d   = 1'b0;
        drop_d  = drop_q;
        take    = 1'b0;
        cur_cnt = cnt_q;
        cur_re  = re_q;
        cur_im  = im_q;
        lane    = 2'd0;
        cnt_inc = '0;
        fin     = 1'b0;
        emit    = 1'b0;

        if (sop) begin
            // A sop always abandons any partial beat before being judged.
            err_d   = (state_q == PACK);
            cur_cnt = '0;
            cur_re  = '0;
            cur_im  = '0;
            re_d    = '0;
            im_d    = '0;
            cnt_d   = '0;
            if (ok) begin
                take    = 1'b1;
                first_d = 1'b1;
                pts_d   = bus.in_dftpts;
                size_d  = bus.in_size;
                state_d = PACK;
            end else begin
                if (drop_q != '1) drop_d = drop_q + 1'b1;
                state_d = bus.in_eop ? IDLE : DROP;
            end
        end else if (bus.in_valid) begin
            if (state_q == PACK) begin
                take = 1'b1;
            end else if (state_q == DROP && bus.in_eop) begin
                state_d = IDLE;
            end
        end

        if (take) begin
            lane         = cur_cnt[1:0];
            cur_re[lane] = bus.in_real;
            cur_im[lane] = bus.in_imag;
            cnt_inc      = cur_cnt + 1'b1;
            fin          = bus.in_eop || (cnt_inc == pts_d);
            emit         = fin || (lane == 2'd3);
            cnt_d        = fin ? '0 : cnt_inc;
            if (emit) begin
                ov_d    = 1'b1;
                osop_d  = first_d;
                oeop_d  = fin;
                ore_d   = cur_re;
                oim_d   = cur_im;
                opts_d  = pts_d;
                osz_d   = size_d;
                first_d = 1'b0;
                re_d    = '0;
                im_d    = '0;
            end else begin
                re_d = cur_re;
                im_d = cur_im;
            end
            // Early eop or missing eop both close the packet with an error.
            if (fin) begin
                state_d = IDLE;
                if (!(bus.in_eop && cnt_inc == pts_d)) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pts_q   <= '0;
            size_q  <= '0;
            re_q    <= '0;
            im_q    <= '0;
            first_q <= 1'b0;
            ov_q    <= 1'b0;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
            ore_q   <= '0;
            oim_q   <= '0;
            opts_q  <= '0;
            osz_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pts_q   <= pts_d;
            size_q  <= size_d;
            re_q    <= re_d;
            im_q    <= im_d;
            first_q <= first_d;
            ov_q    <= ov_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
            ore_q   <= ore_d;
            oim_q   <= oim_d;
            opts_q  <= opts_d;
            osz_q   <= osz_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.out_valid  = ov_q;
    assign bus.out_sop    = osop_q;
    assign bus.out_eop    = oeop_q;
    assign bus.out_real   = ore_q;
    assign bus.out_imag   = oim_q;
    assign bus.out_dftpts = opts_q;
    assign bus.out_size   = osz_q;
    assign bus.err_len    = err_q;
    assign bus.drop_cnt   = drop_q;

endmodule
